// File: rtl/alu_pkg.sv
// Shared definitions for the handshaked ALU: op codes, flag bit positions,
// FSM state encoding and a flag-packing helper.
package alu_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_SRA = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_SLT = 4'd9;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } alu_state_t;

    function automatic logic [3:0] make_flags(input logic n, input logic v,
                                              input logic c, input logic z);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = n;
        f[FLAG_V] = v;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one partial-product step per cycle, WIDTH steps.
// o_done and o_product are valid together in the cycle of the final step.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_start,
    input  logic [WIDTH-1:0]     i_a,
    input  logic [WIDTH-1:0]     i_b,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product
);

    localparam int CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_prod;
    logic [CW-1:0]      r_cnt;
    logic               r_run;

    logic [2*WIDTH-1:0] w_prod_next;
    logic               w_last;

    assign w_prod_next = r_mplier[0] ? (r_prod + r_mcand) : r_prod;
    assign w_last      = r_run && (r_cnt == CW'(WIDTH - 1));

    // The product is taken from the next-value path so the caller can
    // register it on the same edge as the last iteration.
    assign o_done    = w_last;
    assign o_product = w_prod_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b0;
        end else if (i_start) begin
            r_mcand  <= {{WIDTH{1'b0}}, i_a};
            r_mplier <= i_b;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_run    <= 1'b1;
        end else if (r_run) begin
            r_prod   <= w_prod_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            if (w_last) begin
                r_run <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with status flags, sequential multiply and accumulator feedback.
// IDLE accepts a request, BUSY runs the multiplier, DONE holds the result until consumed.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               use_acc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic [3:0]         flags,
    output logic               err
);

    localparam int SHW = $clog2(WIDTH);

    alu_state_t         r_state;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic [3:0]         r_flags;
    logic               r_err;
    logic               r_out_valid;

    logic [WIDTH-1:0]   w_a_eff;
    logic [SHW-1:0]     w_shamt;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_res;
    logic               w_c;
    logic               w_v;
    logic               w_err;
    logic [3:0]         w_flags;
    logic               w_accept;
    logic               w_mul_start;
    logic               w_mul_done;
    logic [2*WIDTH-1:0] w_mul_prod;
    logic [WIDTH-1:0]   w_mul_lo;
    logic [3:0]         w_mul_flags;

    assign w_a_eff     = use_acc ? r_acc : a;
    assign w_shamt     = b[SHW-1:0];
    assign w_accept    = in_valid && (r_state == ST_IDLE);
    assign w_mul_start = w_accept && (op == OP_MUL);

    always_comb begin
        w_sum = '0;
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_err = 1'b0;
        case (op)
            OP_ADD: begin
                w_sum = {1'b0, w_a_eff} + {1'b0, b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (w_a_eff[WIDTH-1] == b[WIDTH-1]) &&
                        (w_res[WIDTH-1] != w_a_eff[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the borrow.
                w_sum = {1'b0, w_a_eff} - {1'b0, b};
                w_res = w_sum[WIDTH-1:0];
                w_c   = ~w_sum[WIDTH];
                w_v   = (w_a_eff[WIDTH-1] != b[WIDTH-1]) &&
                        (w_res[WIDTH-1] != w_a_eff[WIDTH-1]);
            end
            OP_AND: w_res = w_a_eff & b;
            OP_OR:  w_res = w_a_eff | b;
            OP_XOR: w_res = w_a_eff ^ b;
            OP_SHL: w_res = w_a_eff << w_shamt;
            OP_SHR: w_res = w_a_eff >> w_shamt;
            OP_SRA: w_res = $signed(w_a_eff) >>> w_shamt;
            OP_MUL: w_err = 1'b0;
            OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(w_a_eff) < $signed(b))};
            default: w_err = 1'b1;
        endcase
        w_flags = make_flags(w_res[WIDTH-1], w_v, w_c, (w_res == '0));
    end

    alu_mul_seq #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk       (clk),
        .rst       (rst),
        .i_start   (w_mul_start),
        .i_a       (w_a_eff),
        .i_b       (b),
        .o_done    (w_mul_done),
        .o_product (w_mul_prod)
    );

    assign w_mul_lo    = w_mul_prod[WIDTH-1:0];
    assign w_mul_flags = make_flags(w_mul_lo[WIDTH-1], 1'b0,
                                    |w_mul_prod[2*WIDTH-1:WIDTH], (w_mul_lo == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_acc       <= '0;
            r_result    <= '0;
            r_flags     <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        if (op == OP_MUL) begin
                            r_state <= ST_BUSY;
                        end else begin
                            r_result    <= w_res;
                            r_flags     <= w_flags;
                            r_err       <= w_err;
                            r_out_valid <= 1'b1;
                            r_state     <= ST_DONE;
                            // Illegal ops report but leave the accumulator alone.
                            if (!w_err) begin
                                r_acc <= w_res;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    if (w_mul_done) begin
                        r_result    <= w_mul_lo;
                        r_flags     <= w_mul_flags;
                        r_err       <= 1'b0;
                        r_acc       <= w_mul_lo;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign flags     = r_flags;
    assign err       = r_err;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH = 8 with hand-computed expectations.
// Flags are {N,V,C,Z}; latency counts rising edges from the drive until out_valid is seen.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       use_acc;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic [3:0] flags;
    logic       err;

    int errors  = 0;
    int checks  = 0;
    int overlap = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .use_acc   (use_acc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one request, keeps out_ready high, returns what was seen at out_valid.
    task automatic run_op(input logic [3:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                          input logic t_ua, output logic [7:0] o_res, output logic [3:0] o_fl,
                          output logic o_err, output int o_lat, output int o_low);
        int edges;
        bit got;
        @(negedge clk);
        chk("ready_before_request", in_ready, 1);
        op = t_op; a = t_a; b = t_b; use_acc = t_ua; in_valid = 1'b1;
        edges = 0; got = 0; o_lat = 0; o_low = 0;
        o_res = 'x; o_fl = 'x; o_err = 1'bx;
        do begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            edges++;
            if (!in_ready) o_low++;
            if (in_ready && out_valid) overlap++;
            if (out_valid && !got) begin
                got = 1; o_lat = edges;
                o_res = result; o_fl = flags; o_err = err;
            end
        end while (!(got && in_ready) && edges < 50);
    endtask

    task automatic op_check(input string tag, input logic [3:0] t_op, input logic [7:0] t_a,
                            input logic [7:0] t_b, input logic t_ua, input logic [7:0] e_res,
                            input logic [3:0] e_fl, input logic e_err, input int e_lat, input int e_low);
        logic [7:0] r;
        logic [3:0] f;
        logic       e;
        int         lat;
        int         low;
        run_op(t_op, t_a, t_b, t_ua, r, f, e, lat, low);
        chk({tag, ".result"},  r,   e_res);
        chk({tag, ".flags"},   f,   e_fl);
        chk({tag, ".err"},     e,   e_err);
        chk({tag, ".latency"}, lat, e_lat);
        chk({tag, ".busy"},    low, e_low);
    endtask

    initial begin
        int seen;
        rst = 1'b1; in_valid = 1'b0; op = 4'd0; a = 8'h00; b = 8'h00;
        use_acc = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.in_ready",  in_ready,  1);
        chk("reset.out_valid", out_valid, 0);
        chk("reset.result",    result,    8'h00);
        chk("reset.flags",     flags,     4'h0);
        chk("reset.err",       err,       0);
        @(negedge clk); rst = 1'b0;

        // Single-cycle ops: latency 1 edge, in_ready low for one cycle.
        op_check("add_carry",  4'd0, 8'hF0, 8'h20, 0, 8'h10, 4'b0010, 0, 1, 1);
        op_check("add_ovf",    4'd0, 8'h7F, 8'h01, 0, 8'h80, 4'b1100, 0, 1, 1);
        op_check("sub_ovf",    4'd1, 8'h80, 8'h01, 0, 8'h7F, 4'b0110, 0, 1, 1);
        op_check("sub_borrow", 4'd1, 8'h01, 8'h02, 0, 8'hFF, 4'b1000, 0, 1, 1);
        op_check("sub_equal",  4'd1, 8'h05, 8'h05, 0, 8'h00, 4'b0011, 0, 1, 1);

        // Multiply: out_valid 9 edges after the drive, in_ready low 9 cycles.
        op_check("mul_hi",     4'd8, 8'h10, 8'h11, 0, 8'h10, 4'b0010, 0, 9, 9);
        op_check("mul_small",  4'd8, 8'h0F, 8'h03, 0, 8'h2D, 4'b0000, 0, 9, 9);
        op_check("mul_max",    4'd8, 8'hFF, 8'hFF, 0, 8'h01, 4'b0010, 0, 9, 9);

        // Back-pressure: hold the result, ignore new requests while DONE.
        @(negedge clk);
        out_ready = 1'b0;
        op = 4'd0; a = 8'h12; b = 8'h34; use_acc = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("bp.first_valid",  out_valid, 1);
        chk("bp.first_result", result,    8'h46);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            op = 4'd1; a = 8'h01; b = 8'h02; in_valid = 1'b1;
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp.hold_valid",  out_valid, 1);
            chk("bp.hold_result", result,    8'h46);
            chk("bp.hold_flags",  flags,     4'b0000);
            chk("bp.hold_ready",  in_ready,  0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp.release_valid", out_valid, 0);
        chk("bp.release_ready", in_ready,  1);
        @(posedge clk); #1;
        chk("bp.no_phantom", out_valid, 0);

        // Accumulator chain across an illegal op.
        op_check("acc_seed",  4'd0, 8'h05, 8'h03, 0, 8'h08, 4'b0000, 0, 1, 1);
        op_check("acc_add2",  4'd0, 8'hEE, 8'h02, 1, 8'h0A, 4'b0000, 0, 1, 1);
        op_check("illegal",   4'hF, 8'h12, 8'h34, 0, 8'h00, 4'b0001, 1, 1, 1);
        op_check("acc_add1",  4'd0, 8'hEE, 8'h01, 1, 8'h0B, 4'b0000, 0, 1, 1);
        op_check("acc_mul",   4'd8, 8'hEE, 8'h03, 1, 8'h21, 4'b0000, 0, 9, 9);

        // Reset during the 4th BUSY cycle of a multiply.
        @(negedge clk);
        op = 4'd8; a = 8'h33; b = 8'h44; use_acc = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("abort.busy_ready", in_ready, 0);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort.out_valid", out_valid, 0);
        chk("abort.result",    result,    8'h00);
        chk("abort.flags",     flags,     4'h0);
        chk("abort.in_ready",  in_ready,  1);
        @(negedge clk); rst = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("abort.no_output", seen, 0);
        op_check("acc_cleared", 4'd0, 8'hFF, 8'h07, 1, 8'h07, 4'b0000, 0, 1, 1);

        // Shifts, logic and compare.
        op_check("shl",       4'd5, 8'h81, 8'h01, 0, 8'h02, 4'b0000, 0, 1, 1);
        op_check("shl_wrap",  4'd5, 8'h01, 8'h09, 0, 8'h02, 4'b0000, 0, 1, 1);
        op_check("sra",       4'd7, 8'h80, 8'h03, 0, 8'hF0, 4'b1000, 0, 1, 1);
        op_check("shr",       4'd6, 8'h80, 8'h03, 0, 8'h10, 4'b0000, 0, 1, 1);
        op_check("and",       4'd2, 8'hF0, 8'h3C, 0, 8'h30, 4'b0000, 0, 1, 1);
        op_check("or",        4'd3, 8'h0F, 8'h80, 0, 8'h8F, 4'b1000, 0, 1, 1);
        op_check("xor_zero",  4'd4, 8'hAA, 8'hAA, 0, 8'h00, 4'b0001, 0, 1, 1);
        op_check("slt_true",  4'd9, 8'hFF, 8'h01, 0, 8'h01, 4'b0000, 0, 1, 1);
        op_check("slt_false", 4'd9, 8'h01, 8'hFF, 0, 8'h00, 4'b0001, 0, 1, 1);

        chk("ready_valid_overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
